// File: rtl/sub_serial_if.sv
// sub_serial_if: start/done handshake and operand/result bus for sub_serial; ovf exists only with SUB_SERIAL_OVF_EN
interface sub_serial_if #(parameter int WIDTH = 4);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             b_in;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] diff;
    logic             b_out;
`ifdef SUB_SERIAL_OVF_EN
    logic             ovf;
    modport master (output start, a, b, b_in, input busy, done, diff, b_out, ovf);
    modport slave  (input start, a, b, b_in, output busy, done, diff, b_out, ovf);
`else
    modport master (output start, a, b, b_in, input busy, done, diff, b_out);
    modport slave  (input start, a, b, b_in, output busy, done, diff, b_out);
`endif
endinterface

// File: rtl/sub_serial.sv
// sub_serial: bit-serial subtractor, diff = a - b - b_in one bit per clock LSB first; SUB_SERIAL_OVF_EN adds signed overflow flag ovf
module sub_serial #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 5
) (
    input logic         clk,
    input logic         rst,
    sub_serial_if.slave io_bus
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t           r_state, w_next;
    logic [WIDTH-1:0] r_a_sh, r_b_sh, r_res, r_diff;
    logic [CNT_W-1:0] r_cnt;
    logic             r_borrow, r_b_out;
    logic             w_d, w_borrow_next, w_accept, w_last;
`ifdef SUB_SERIAL_OVF_EN
    logic             r_a_msb, r_b_msb, r_ovf;
`endif
    assign w_d           = r_a_sh[0] ^ r_b_sh[0] ^ r_borrow;
    assign w_borrow_next = (~r_a_sh[0] & r_b_sh[0]) | (~(r_a_sh[0] ^ r_b_sh[0]) & r_borrow);
    assign w_accept      = (r_state == IDLE) && io_bus.start;
    assign w_last        = (r_state == RUN) && (r_cnt == CNT_W'(WIDTH - 1));
    assign io_bus.diff   = r_diff;
    assign io_bus.b_out  = r_b_out;
`ifdef SUB_SERIAL_OVF_EN
    assign io_bus.ovf    = r_ovf;
`endif
    // state register
    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next;
    end
    // next state and handshake outputs
    always_comb begin
        w_next      = r_state;
        io_bus.busy = (r_state == RUN) || (r_state == DONE);
        io_bus.done = (r_state == DONE);
        if (w_accept)               w_next = RUN;
        else if (w_last)            w_next = DONE;
        else if (r_state == DONE)   w_next = IDLE;
    end
    // operand capture, serial full-subtractor step and result latch on the final bit
    always_ff @(posedge clk) begin
        if (rst) begin
            r_a_sh   <= '0;
            r_b_sh   <= '0;
            r_res    <= '0;
            r_diff   <= '0;
            r_cnt    <= '0;
            r_borrow <= 1'b0;
            r_b_out  <= 1'b0;
`ifdef SUB_SERIAL_OVF_EN
            r_a_msb  <= 1'b0;
            r_b_msb  <= 1'b0;
            r_ovf    <= 1'b0;
`endif
        end else if (w_accept) begin
            r_a_sh   <= io_bus.a;
            r_b_sh   <= io_bus.b;
            r_borrow <= io_bus.b_in;
            r_cnt    <= '0;
`ifdef SUB_SERIAL_OVF_EN
            r_a_msb  <= io_bus.a[WIDTH-1];
            r_b_msb  <= io_bus.b[WIDTH-1];
`endif
        end else if (r_state == RUN) begin
            r_a_sh   <= r_a_sh >> 1;
            r_b_sh   <= r_b_sh >> 1;
            r_borrow <= w_borrow_next;
            r_res    <= {w_d, r_res[WIDTH-1:1]};
            r_cnt    <= r_cnt + CNT_W'(1);
            if (w_last) begin
                r_diff  <= {w_d, r_res[WIDTH-1:1]};
                r_b_out <= w_borrow_next;
`ifdef SUB_SERIAL_OVF_EN
                r_ovf   <= (r_a_msb != r_b_msb) && (w_d != r_a_msb);
`endif
            end
        end
    end
endmodule

// File: tb/tb_sub_serial.sv
// tb_sub_serial: directed and randomized self-checking bench for sub_serial against an arithmetic reference model
module tb_sub_serial;
    localparam int WIDTH = 4;
    logic clk, rst;
    int   checks, failures, done_seen, done_exp;
    logic [WIDTH-1:0] qa [3];
    logic [WIDTH-1:0] qb [3];
    logic             qbi [3];

    sub_serial_if #(.WIDTH(WIDTH)) bus ();
    sub_serial #(.WIDTH(WIDTH), .CNT_W(5)) dut (.clk(clk), .rst(rst), .io_bus(bus));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // counts every done pulse seen, to catch missing or extra pulses
    always @(negedge clk) if (bus.done === 1'b1) done_seen++;

    function automatic logic [31:0] m_diff(int a, int b, int bi);
        return 32'((a - b - bi) & ((1 << WIDTH) - 1));
    endfunction

    function automatic logic [31:0] m_bout(int a, int b, int bi);
        return (a < b + bi) ? 32'd1 : 32'd0;
    endfunction

    function automatic logic [31:0] m_ovf(int a, int b, int bi);
        int sa, sb, r;
        sa = (a >= (1 << (WIDTH - 1))) ? a - (1 << WIDTH) : a;
        sb = (b >= (1 << (WIDTH - 1))) ? b - (1 << WIDTH) : b;
        r  = sa - sb - bi;
        return (r < -(1 << (WIDTH - 1)) || r > (1 << (WIDTH - 1)) - 1) ? 32'd1 : 32'd0;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic run_op(input logic [WIDTH-1:0] ta, input logic [WIDTH-1:0] tb, input logic tbi);
        int n, bc;
        @(negedge clk);
        bus.start = 1'b1; bus.a = ta; bus.b = tb; bus.b_in = tbi;
        @(negedge clk);
        bus.start = 1'b0; bus.a = WIDTH'($urandom); bus.b = WIDTH'($urandom); bus.b_in = 1'($urandom);
        n = 1; bc = 0;
        while (bus.done !== 1'b1 && n < 20) begin
            if (bus.busy === 1'b1) bc++;
            @(negedge clk);
            n++;
        end
        if (bus.busy === 1'b1) bc++;
        done_exp++;
        chk("latency", 32'(n), 32'(WIDTH + 1));
        chk("busy_cycles", 32'(bc), 32'(WIDTH + 1));
        chk("diff", 32'(bus.diff), m_diff(int'(ta), int'(tb), int'(tbi)));
        chk("b_out", 32'(bus.b_out), m_bout(int'(ta), int'(tb), int'(tbi)));
`ifdef SUB_SERIAL_OVF_EN
        chk("ovf", 32'(bus.ovf), m_ovf(int'(ta), int'(tb), int'(tbi)));
`endif
    endtask

    initial begin
        checks = 0; failures = 0; done_seen = 0; done_exp = 0;
        rst = 1'b1; bus.start = 1'b0; bus.a = '0; bus.b = '0; bus.b_in = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("rst_busy", 32'(bus.busy), 32'd0);
            chk("rst_done", 32'(bus.done), 32'd0);
            chk("rst_diff", 32'(bus.diff), 32'd0);
            chk("rst_bout", 32'(bus.b_out), 32'd0);
`ifdef SUB_SERIAL_OVF_EN
            chk("rst_ovf", 32'(bus.ovf), 32'd0);
`endif
        end
        run_op(4'd9, 4'd3, 1'b0);
        chk("basic_diff", 32'(bus.diff), 32'd6);
        @(negedge clk);
        chk("done_pulse_end", 32'(bus.done), 32'd0);
        chk("idle_busy", 32'(bus.busy), 32'd0);
        bus.start = 1'b1; bus.a = 4'd7; bus.b = 4'd1; bus.b_in = 1'b0;
        @(negedge clk);
        bus.start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("midrst_busy", 32'(bus.busy), 32'd0);
        chk("midrst_diff", 32'(bus.diff), 32'd0);
        chk("midrst_bout", 32'(bus.b_out), 32'd0);
        for (int i = 0; i < 8; i++) begin
            chk("midrst_nodone", 32'(bus.done), 32'd0);
            @(negedge clk);
        end
        run_op(4'd15, 4'd15, 1'b1);
        chk("ff_diff", 32'(bus.diff), 32'd15);
        chk("ff_bout", 32'(bus.b_out), 32'd1);
        run_op(4'd2, 4'd5, 1'b1);
        chk("wrap_diff", 32'(bus.diff), 32'd12);
        chk("wrap_bout", 32'(bus.b_out), 32'd1);
        run_op(4'd8, 4'd1, 1'b0);
        chk("ovf_case_diff", 32'(bus.diff), 32'd7);
`ifdef SUB_SERIAL_OVF_EN
        chk("ovf_case_ovf", 32'(bus.ovf), 32'd1);
`endif
        run_op(4'd0, 4'd0, 1'b1);
        chk("zero_bin_diff", 32'(bus.diff), 32'd15);
        run_op(4'd0, 4'd15, 1'b1);
        chk("zero_ff_diff", 32'(bus.diff), 32'd0);
        chk("zero_ff_bout", 32'(bus.b_out), 32'd1);
        @(negedge clk);
        for (int j = 0; j <= 18; j++) begin
            if (j >= 1) begin
                logic exp_done;
                exp_done = (j >= 5) && ((j - 5) % 6 == 0);
                chk("hold_done", 32'(bus.done), 32'(exp_done));
                if (exp_done) begin
                    int k;
                    k = (j - 5) / 6;
                    done_exp++;
                    chk("hold_diff", 32'(bus.diff), m_diff(int'(qa[k]), int'(qb[k]), int'(qbi[k])));
                    chk("hold_bout", 32'(bus.b_out), m_bout(int'(qa[k]), int'(qb[k]), int'(qbi[k])));
                end
            end
            bus.start = (j < 18);
            bus.a = WIDTH'($urandom); bus.b = WIDTH'($urandom); bus.b_in = 1'($urandom);
            if (j % 6 == 0 && j < 18) begin
                qa[j / 6] = bus.a; qb[j / 6] = bus.b; qbi[j / 6] = bus.b_in;
            end
            @(negedge clk);
        end
        chk("hold_idle", 32'(bus.busy), 32'd0);
        for (int x = 0; x < 16; x++)
            for (int y = 0; y < 16; y++)
                for (int z = 0; z < 2; z++)
                    run_op(WIDTH'(x), WIDTH'(y), 1'(z));
        repeat (3) @(negedge clk);
        chk("done_count", 32'(done_seen), 32'(done_exp));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
